// File: rtl/seg_scan_display.sv
// Two-digit multiplexed 7-segment driver for a seconds timer.
// Digits are sampled once per frame, so the two halves of a frame always agree.

module seg_scan_display #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 250
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [3:0] T_Sec0,
  input  logic [3:0] T_Sec1,
  input  logic       Blink_En,
  output logic [6:0] Seg,
  output logic [1:0] Com,
  output logic       Frame
);

  // state     | meaning
  // SLOT_ONES | Com[0] active, ones digit on the segments
  // SLOT_TENS | Com[1] active, tens digit (blanked if zero)

  localparam int SW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(BLINK_FRAMES);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  typedef enum logic {
    SLOT_ONES = 1'b0,
    SLOT_TENS = 1'b1
  } slot_e;

  slot_e         slot_q, slot_d;
  logic [SW-1:0] scan_cnt_q, scan_cnt_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          phase_q, phase_d;
  logic [3:0]    dig0_q, dig0_d;
  logic [3:0]    dig1_q, dig1_d;
  logic          scan_tc;
  logic          frame_tick;
  logic [3:0]    shown;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      slot_q      <= SLOT_ONES;
      scan_cnt_q  <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      dig0_q      <= '0;
      dig1_q      <= '0;
    end else begin
      slot_q      <= slot_d;
      scan_cnt_q  <= scan_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      dig0_q      <= dig0_d;
      dig1_q      <= dig1_d;
    end
  end

  always_comb begin
    scan_tc     = (scan_cnt_q == SCAN_LAST);
    frame_tick  = scan_tc && (slot_q == SLOT_TENS);
    scan_cnt_d  = scan_tc ? '0 : scan_cnt_q + SW'(1);
    slot_d      = slot_q;
    dig0_d      = dig0_q;
    dig1_d      = dig1_q;
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;

    if (scan_tc) begin
      slot_d = (slot_q == SLOT_ONES) ? SLOT_TENS : SLOT_ONES;
    end

    if (frame_tick) begin
      dig0_d = T_Sec0;
      dig1_d = T_Sec1;
    end

    // Holding the blink state at zero while disabled makes every enable start visible.
    if (!Blink_En) begin
      blink_cnt_d = '0;
      phase_d     = 1'b0;
    end else if (frame_tick) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end
  end

  always_comb begin
    Seg   = 7'h00;
    Com   = 2'b11;
    Frame = frame_tick;
    shown = (slot_q == SLOT_TENS) ? dig1_q : dig0_q;

    if (Blink_En && phase_q) begin
      Seg = 7'h00;
      Com = 2'b11;
    end else if ((slot_q == SLOT_TENS) && (dig1_q == 4'd0)) begin
      Seg = 7'h00;
      Com = 2'b11;
    end else begin
      Seg = seg_decode(shown);
      Com = (slot_q == SLOT_TENS) ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: tb/tb_seg_scan_display.sv
// Bench for seg_scan_display: directed scenarios then random traffic, all
// outputs compared every cycle against a cycle-count reference model.

module tb_seg_scan_display;

  localparam int SD = 4;
  localparam int BF = 2;
  localparam int FL = 2 * SD;

  logic       Clk = 1'b0;
  logic       Rst = 1'b0;
  logic [3:0] T_Sec0 = 4'd0;
  logic [3:0] T_Sec1 = 4'd0;
  logic       Blink_En = 1'b0;
  logic [6:0] Seg;
  logic [1:0] Com;
  logic       Frame;

  int tests = 0;
  int fails = 0;

  // model: cycles since reset release, latched digits, frames seen while enabled
  int         m_t;
  int         m_nfr;
  logic [3:0] m_l0, m_l1;
  logic [6:0] seg_tab [16];

  seg_scan_display #(.SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
    .Clk(Clk), .Rst(Rst), .T_Sec0(T_Sec0), .T_Sec1(T_Sec1),
    .Blink_En(Blink_En), .Seg(Seg), .Com(Com), .Frame(Frame)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_t = 0; m_nfr = 0; m_l0 = 4'd0; m_l1 = 4'd0;
  endtask

  function automatic int m_phase();
    return (m_nfr / BF) % 2;
  endfunction

  task automatic model_step();
    bit boundary;
    if (!Rst) begin
      model_reset();
    end else begin
      boundary = ((m_t % FL) == FL - 1);
      if (boundary) begin
        m_l0 = T_Sec0;
        m_l1 = T_Sec1;
      end
      if (!Blink_En) m_nfr = 0;
      else if (boundary) m_nfr++;
      m_t++;
    end
  endtask

  task automatic check_model(input string tag);
    int         slot;
    logic [6:0] e_seg;
    logic [1:0] e_com;
    logic       e_frm;
    slot  = (m_t / SD) % 2;
    e_frm = Rst && ((m_t % FL) == FL - 1);
    if ((Blink_En && m_phase() == 1) || (slot == 1 && m_l1 == 4'd0)) begin
      e_seg = 7'h00; e_com = 2'b11;
    end else begin
      e_seg = seg_tab[(slot == 1) ? m_l1 : m_l0];
      e_com = (slot == 1) ? 2'b01 : 2'b10;
    end
    check({tag, ".seg"}, 8'(Seg), 8'(e_seg));
    check({tag, ".com"}, 8'(Com), 8'(e_com));
    check({tag, ".frame"}, 8'(Frame), 8'(e_frm));
  endtask

  task automatic tick(input string tag);
    @(negedge Clk);
    check_model(tag);
    @(posedge Clk);
    #1;
    model_step();
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  task automatic align(input string tag, input int pos);
    for (int i = 0; i < FL; i++) begin
      if ((m_t % FL) == pos) break;
      tick(tag);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".seg"}, 8'(Seg), 8'h3F);
    check({tag, ".com"}, 8'(Com), 8'h02);
    check({tag, ".frame"}, 8'(Frame), 8'h00);
  endtask

  initial begin
    int  edges;
    bit  found;
    seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
    model_reset();

    #1;
    check_reset_outputs("reset_hold");
    run("reset", 3);

    // zeros: ones shows 0, tens blanked, Frame every 8 cycles
    Rst = 1'b1;
    run("zeros", 3 * FL);

    // new digits mid-frame must wait for the boundary
    align("to_mid", 2);
    T_Sec1 = 4'd4; T_Sec0 = 4'd7;
    tick("mid_frame");
    check("mid_frame_hold", 8'(Seg), 8'h3F);
    run("digits_47", 3 * FL);

    // change ones at cycle 2 of a frame: no torn frame
    T_Sec1 = 4'd3; T_Sec0 = 4'd9;
    run("tear_setup", FL);
    align("tear_align", 2);
    T_Sec0 = 4'd0;
    run("tear", 3 * FL);

    T_Sec0 = 4'hC;
    run("dash", 2 * FL);
    T_Sec0 = 4'hF; T_Sec1 = 4'hA;
    run("dash_both", 2 * FL);

    // blink with 5,9
    T_Sec1 = 4'd5; T_Sec0 = 4'd9;
    run("blink_setup", FL);
    align("blink_align", 0);
    Blink_En = 1'b1;
    run("blink", 6 * FL);
    for (int i = 0; i < 8 * FL; i++) begin
      if (m_phase() == 1 && (m_t % FL) == 3) break;
      tick("blink_find_dark");
    end
    #1;
    check("dark_com", 8'(Com), 8'h03);
    check("dark_seg", 8'(Seg), 8'h00);
    Blink_En = 1'b0;
    #1;
    check("unblink_com", 8'(Com), 8'h02);
    check("unblink_seg", 8'(Seg), 8'h6F);
    run("unblink", 2 * FL);

    // reset at cycle 3 of the tens slot
    align("rst_align", FL - 1);
    Rst = 1'b0;
    model_reset();
    #1;
    check_reset_outputs("midframe_rst");
    run("in_rst", 2);
    Rst = 1'b1;
    edges = 0;
    found = 0;
    for (int i = 0; i < 5 * FL; i++) begin
      @(negedge Clk);
      check_model("post_rst");
      if (Frame === 1'b1) begin
        found = 1;
        break;
      end
      @(posedge Clk);
      #1;
      model_step();
      edges++;
    end
    check("post_rst_frame_seen", 8'(found), 8'h01);
    check("post_rst_frame_edges", 8'(edges), 8'(FL - 1));
    if (found) begin
      @(posedge Clk);
      #1;
      model_step();
    end
    run("post_rst_run", FL);

    // random traffic
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(5) == 0) begin
        T_Sec0 = 4'($urandom_range(15));
        T_Sec1 = ($urandom_range(3) == 0) ? 4'd0 : 4'($urandom_range(15));
      end
      if ($urandom_range(24) == 0) Blink_En = ~Blink_En;
      if ($urandom_range(250) == 0) begin
        Rst = 1'b0;
        model_reset();
        #1;
        check_reset_outputs("rand_rst");
        tick("rand_in_rst");
        Rst = 1'b1;
      end
      tick("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seg_scan_display.md
SEG_SCAN_DISPLAY -- requirements
Module: seg_scan_display

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, clock cycles each digit is driven (1 ms at 50 MHz).
REQ-002 SHALL have parameter BLINK_FRAMES, default 250, frames per blink half-period (0.5 s at defaults).
REQ-003 SHALL have port Clk, input, 1, system clock; all state changes on rising edge.
REQ-004 SHALL have port Rst, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port T_Sec0, input, 4, BCD ones-of-seconds digit from the timer.
REQ-006 SHALL have port T_Sec1, input, 4, BCD tens-of-seconds digit from the timer.
REQ-007 SHALL have port Blink_En, input, 1, 1 = flash the display (timer paused/expired).
REQ-008 SHALL have port Seg, output, 7, segments {g,f,e,d,c,b,a}, active-high.
REQ-009 SHALL have port Com, output, 2, digit commons, active-low; Com[0] = ones, Com[1] = tens.
REQ-010 SHALL have port Frame, output, 1, one-cycle pulse at each frame boundary.

Function
REQ-011 Scan counter SHALL count 0..SCAN_DIV-1 and wrap; terminal count (TC) = counter at SCAN_DIV-1.
REQ-012 Digit index SHALL toggle on every TC; index 0 drives the ones digit, index 1 the tens digit.
REQ-013 Frame boundary = TC while index = 1; Frame SHALL be high for exactly that cycle.
REQ-014 T_Sec0 and T_Sec1 SHALL be latched only on a frame boundary, so both digits shown in one frame come from the same sample (no tearing); the latched value is visible from the next cycle.
REQ-015 Decode of latched digit SHALL be 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F (hex).
REQ-016 Latched digit values A-F SHALL display as dash (Seg = 40).
REQ-017 Leading-zero blanking: when index = 1 and latched tens = 0, Com SHALL be 11 and Seg SHALL be 00; the ones digit is never blanked by this rule.
REQ-018 Active digit: Com SHALL be 10 for index 0 and 01 for index 1; never 00.
REQ-019 Blink frame counter SHALL count frame boundaries 0..BLINK_FRAMES-1 and wrap; the blink phase toggles on the wrap.
REQ-020 When Blink_En = 1 and phase = 1, Com SHALL be 11 and Seg SHALL be 00 for both digits.
REQ-021 When Blink_En = 0, the frame counter and phase SHALL be held at 0 on the next edge, so re-enabling always starts with a visible half-period.
REQ-022 Blink_En SHALL have no effect on scan timing or digit latching.
REQ-023 Seg and Com SHALL be a pure decode of registered state (index, latched digits, phase, Blink_En); there is no input-to-output combinational path from T_Sec0 or T_Sec1.
REQ-024 Counter widths SHALL be $clog2 of the respective parameter; parameters of at least 2 are supported.

Reset
REQ-025 Rst low SHALL immediately clear the scan counter, index, latched digits, blink counter and phase to 0.
REQ-026 Outputs during and after reset SHALL be Com = 10, Seg = 3F ("0" on the ones digit), Frame = 0.
REQ-027 Reset asserted mid-frame SHALL abandon the frame; the first post-reset frame boundary occurs 2*SCAN_DIV cycles after release.

Verification (SCAN_DIV=4, BLINK_FRAMES=2)
REQ-028 Release reset with T_Sec1=0, T_Sec0=0 -> Com 10/Seg 3F for 4 cycles, then Com 11/Seg 00 for 4 cycles, repeating; Frame pulses every 8 cycles.
REQ-029 Set digits to 4,7 mid-frame -> display unchanged until the Frame pulse; then ones shows 07 and tens shows 66.
REQ-030 Set T_Sec1=3 and change T_Sec0 9->0 at cycle 2 of a frame -> no frame shows tens from one sample with ones from another.
REQ-031 T_Sec0=C -> ones digit shows Seg 40.
REQ-032 Blink_En=1 with digits 5,9 -> 2 frames visible, then 2 frames with Com 11/Seg 00, repeating; drop Blink_En during a dark phase -> visible from the next cycle.
REQ-033 Pulse Rst low at cycle 3 of the tens slot -> Com 10/Seg 3F at once; next Frame pulse occurs 8 cycles after release.
